// File: rtl/avr_irq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : avr_irq_ctrl_if
//  Description : Core-side bus of the AVR interrupt controller: I/O register
//                port plus the interrupt request / acknowledge handshake.
//  Revision    : 1.0  initial release
// ============================================================================
interface avr_irq_ctrl_if;
   logic       io_re;
   logic       io_we;
   logic [1:0] io_a;
   logic [7:0] io_din;
   logic [7:0] io_dout;
   logic       ieack_stb;
   logic [1:0] ieack;
   logic       iflag;
   logic [1:0] ivect;

   // Core side: drives strobes, address, data and acknowledges
   modport master (
      output io_re, io_we, io_a, io_din, ieack_stb, ieack,
      input  io_dout, iflag, ivect
   );

   // Controller side: answers reads and raises the interrupt request
   modport slave (
      input  io_re, io_we, io_a, io_din, ieack_stb, ieack,
      output io_dout, iflag, ivect
   );
endinterface
`default_nettype wire

// File: rtl/avr_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : avr_irq_ctrl
//  Description : Four-source interrupt controller for an AVR-style core.
//                Per-source enable and edge/level mode, W1C pending register,
//                global enable, fixed priority (source 0 highest), registered
//                request/vector outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module avr_irq_ctrl #(
   parameter logic [3:0] RESET_ENABLE = 4'b0000,
   parameter logic [3:0] RESET_MODE   = 4'b0000
) (
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic [3:0] irq_in,
   avr_irq_ctrl_if.slave   bus
);

   // Register addresses
   localparam logic [1:0] c_ADDR_ENABLE  = 2'd0;
   localparam logic [1:0] c_ADDR_PENDING = 2'd1;
   localparam logic [1:0] c_ADDR_MODE    = 2'd2;
   localparam logic [1:0] c_ADDR_CTRL    = 2'd3;

   logic [3:0] r_enable;
   logic [3:0] r_mode;       // 1 = edge, 0 = level
   logic       r_gie;
   logic [3:0] r_pending;
   logic [3:0] r_irq_q;
   // A line must be seen low after reset before its rising edge counts, so a
   // line held high through reset does not look like a fresh edge.
   logic [3:0] r_armed;
   logic       r_iflag;
   logic [1:0] r_ivect;

   logic       w_wr_enable;
   logic       w_wr_pending;
   logic       w_wr_mode;
   logic       w_wr_ctrl;
   logic [3:0] w_edge;
   logic [3:0] w_w1c;
   logic [3:0] w_ack;
   logic [3:0] w_clr;
   logic [3:0] w_mode_chg;
   logic [3:0] w_pending_next;
   logic [3:0] w_active;
   logic [1:0] w_ivect;
   logic       w_unused_din;

   assign w_wr_enable  = bus.io_we && (bus.io_a == c_ADDR_ENABLE);
   assign w_wr_pending = bus.io_we && (bus.io_a == c_ADDR_PENDING);
   assign w_wr_mode    = bus.io_we && (bus.io_a == c_ADDR_MODE);
   assign w_wr_ctrl    = bus.io_we && (bus.io_a == c_ADDR_CTRL);

   assign w_edge     = irq_in & ~r_irq_q & r_armed;
   assign w_w1c      = w_wr_pending   ? bus.io_din[3:0] : 4'b0000;
   assign w_ack      = bus.ieack_stb  ? (4'b0001 << bus.ieack) : 4'b0000;
   assign w_clr      = w_w1c | w_ack;
   assign w_mode_chg = w_wr_mode      ? (bus.io_din[3:0] ^ r_mode) : 4'b0000;
   assign w_active   = r_pending & r_enable & {4{r_gie}};

   // Data bits 6:4 have no writable register behind them
   assign w_unused_din = ^bus.io_din[6:4];

   // Next pending state: mode change clears, edge sources set-wins over clears,
   // level sources simply follow the line
   always_comb begin
      w_pending_next = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         if (w_mode_chg[i]) begin
            w_pending_next[i] = 1'b0;
         end else if (r_mode[i]) begin
            w_pending_next[i] = (r_pending[i] & ~w_clr[i]) | w_edge[i];
         end else begin
            w_pending_next[i] = irq_in[i];
         end
      end
   end

   // Fixed-priority encoder: lowest active index wins, 0 when nothing active
   always_comb begin
      w_ivect = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (w_active[i]) begin
            w_ivect = 2'(i);
         end
      end
   end

   // Software-visible configuration registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_enable <= RESET_ENABLE;
         r_mode   <= RESET_MODE;
         r_gie    <= 1'b0;
      end else begin
         if (w_wr_enable) begin
            r_enable <= bus.io_din[3:0];
         end
         if (w_wr_mode) begin
            r_mode <= bus.io_din[3:0];
         end
         if (w_wr_ctrl) begin
            r_gie <= bus.io_din[7];
         end
      end
   end

   // Input sampling, edge arming and pending state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_irq_q   <= 4'b0000;
         r_armed   <= 4'b0000;
         r_pending <= 4'b0000;
      end else begin
         r_irq_q   <= irq_in;
         r_armed   <= r_armed | ~irq_in;
         r_pending <= w_pending_next;
      end
   end

   // Registered interrupt request and vector, one clock behind pending
   always_ff @(posedge clk) begin
      if (rst) begin
         r_iflag <= 1'b0;
         r_ivect <= 2'd0;
      end else begin
         r_iflag <= |w_active;
         r_ivect <= w_ivect;
      end
   end

   assign bus.iflag = r_iflag;
   assign bus.ivect = r_ivect;

   // Read mux; drives zero when not selected so it can share a wired-OR bus
   always_comb begin
      bus.io_dout = 8'h00;
      if (bus.io_re) begin
         case (bus.io_a)
            c_ADDR_ENABLE:  bus.io_dout = {4'b0000, r_enable};
            c_ADDR_PENDING: bus.io_dout = {4'b0000, r_pending};
            c_ADDR_MODE:    bus.io_dout = {4'b0000, r_mode};
            c_ADDR_CTRL:    bus.io_dout = {r_gie, r_iflag, 4'b0000, r_ivect};
            default:        bus.io_dout = 8'h00;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_avr_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avr_irq_ctrl
//  Description : Self-checking bench for avr_irq_ctrl: register table vectors
//                followed by directed interrupt sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_avr_irq_ctrl;

   typedef struct {
      logic       wr;
      logic [1:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp;
      string      name;
   } vec_t;

   localparam int c_NVEC = 11;

   logic       clk;
   logic       rst;
   logic [3:0] irq_in;
   int         n_pass;
   int         n_total;
   vec_t       vecs [c_NVEC];

   avr_irq_ctrl_if bus ();

   avr_irq_ctrl #(
      .RESET_ENABLE (4'h0),
      .RESET_MODE   (4'hF)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .irq_in (irq_in),
      .bus    (bus)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %02h expected %02h", nm, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      bus.io_we  = 1'b1;
      bus.io_a   = a;
      bus.io_din = d;
      tick();
      bus.io_we  = 1'b0;
      bus.io_din = 8'h00;
   endtask

   task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string nm);
      bus.io_re = 1'b1;
      bus.io_a  = a;
      #1;
      chk(nm, bus.io_dout, exp);
      bus.io_re = 1'b0;
   endtask

   task automatic chk_out(input logic f, input logic [1:0] v, input string nm);
      chk(nm, {5'b00000, bus.iflag, bus.ivect}, {5'b00000, f, v});
   endtask

   task automatic ack(input logic [1:0] v);
      bus.ieack_stb = 1'b1;
      bus.ieack     = v;
      tick();
      bus.ieack_stb = 1'b0;
      bus.ieack     = 2'd0;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      //          wr    addr  wdata  exp    name
      vecs[0]  = '{1'b0, 2'd0, 8'h00, 8'h00, "rst_enable"};
      vecs[1]  = '{1'b0, 2'd1, 8'h00, 8'h00, "rst_pending"};
      vecs[2]  = '{1'b0, 2'd2, 8'h00, 8'h0F, "rst_mode"};
      vecs[3]  = '{1'b0, 2'd3, 8'h00, 8'h00, "rst_ctrl"};
      vecs[4]  = '{1'b1, 2'd0, 8'hA5, 8'h05, "enable_wr"};
      vecs[5]  = '{1'b1, 2'd2, 8'hF3, 8'h03, "mode_wr"};
      vecs[6]  = '{1'b1, 2'd2, 8'hFF, 8'h0F, "mode_restore"};
      vecs[7]  = '{1'b1, 2'd3, 8'h7F, 8'h00, "ctrl_only_gie"};
      vecs[8]  = '{1'b1, 2'd3, 8'h80, 8'h80, "ctrl_gie"};
      vecs[9]  = '{1'b1, 2'd0, 8'h0F, 8'h0F, "enable_all"};
      vecs[10] = '{1'b1, 2'd1, 8'hFF, 8'h00, "w1c_idle"};

      rst           = 1'b1;
      irq_in        = 4'h0;
      bus.io_re     = 1'b0;
      bus.io_we     = 1'b0;
      bus.io_a      = 2'd0;
      bus.io_din    = 8'h00;
      bus.ieack_stb = 1'b0;
      bus.ieack     = 2'd0;
      tick();
      tick();
      rst = 1'b0;
      chk_out(1'b0, 2'd0, "rst_outputs");

      // Register table
      for (int i = 0; i < c_NVEC; i++) begin
         if (vecs[i].wr) begin
            wr(vecs[i].addr, vecs[i].wdata);
         end
         rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
      end

      // Single edge pulse on source 2: request exactly two clocks later
      irq_in = 4'b0100;
      tick();
      irq_in = 4'b0000;
      chk_out(1'b0, 2'd0, "edge_lat1");
      tick();
      chk_out(1'b1, 2'd2, "edge_lat2");
      rd(2'd1, 8'h04, "edge_pend");
      wr(2'd1, 8'h04);
      tick();
      chk_out(1'b0, 2'd0, "w1c_drop");

      // Sources 1 and 3 pending: priority, then acknowledge of 1
      irq_in = 4'b1010;
      tick();
      irq_in = 4'b0000;
      tick();
      chk_out(1'b1, 2'd1, "prio_1_over_3");
      ack(2'd1);
      rd(2'd1, 8'h08, "ack_clears_1");
      tick();
      chk_out(1'b1, 2'd3, "after_ack_vec3");

      // Acknowledge of source 3 in the same cycle as a new edge on it
      irq_in = 4'b1000;
      ack(2'd3);
      irq_in = 4'b0000;
      rd(2'd1, 8'h08, "ack_set_wins");
      wr(2'd1, 8'h08);
      rd(2'd1, 8'h00, "w1c_clear_3");
      tick();
      tick();

      // New edge on source 1 together with a W1C of the same bit
      irq_in = 4'b0010;
      wr(2'd1, 8'h02);
      irq_in = 4'b0000;
      rd(2'd1, 8'h02, "w1c_set_wins");
      wr(2'd1, 8'h02);
      rd(2'd1, 8'h00, "w1c_clear_1");
      tick();
      tick();

      // Level source 0 ignores ack and W1C, follows the line
      wr(2'd2, 8'hFE);
      irq_in = 4'b0001;
      tick();
      tick();
      chk_out(1'b1, 2'd0, "level_on");
      ack(2'd0);
      chk_out(1'b1, 2'd0, "level_after_ack");
      wr(2'd1, 8'h01);
      chk_out(1'b1, 2'd0, "level_after_w1c");
      tick();
      chk_out(1'b1, 2'd0, "level_hold");
      irq_in = 4'b0000;
      tick();
      chk_out(1'b1, 2'd0, "level_drop_1clk");
      tick();
      chk_out(1'b0, 2'd0, "level_drop_2clk");

      // Mode change clears only the changed source
      irq_in = 4'b1001;
      tick();
      irq_in = 4'b0001;
      rd(2'd1, 8'h09, "pend_level_edge");
      wr(2'd2, 8'hFF);
      rd(2'd1, 8'h08, "mode_chg_clear");
      tick();
      rd(2'd1, 8'h08, "mode_chg_no_edge");
      irq_in = 4'b0000;
      wr(2'd1, 8'h08);
      tick();
      tick();

      // Masking by ENABLE and GIE leaves pending untouched
      wr(2'd0, 8'h00);
      irq_in = 4'b0100;
      tick();
      irq_in = 4'b0000;
      tick();
      tick();
      chk_out(1'b0, 2'd0, "masked_no_irq");
      rd(2'd1, 8'h04, "masked_pend");
      wr(2'd0, 8'h04);
      chk_out(1'b0, 2'd0, "enable_wr_edge");
      tick();
      chk_out(1'b1, 2'd2, "reenable_irq");
      rd(2'd3, 8'hC2, "ctrl_read_c2");
      bus.io_re = 1'b0;
      bus.io_a  = 2'd3;
      #1;
      chk("re_low_zero", bus.io_dout, 8'h00);
      wr(2'd3, 8'h00);
      tick();
      chk_out(1'b0, 2'd0, "gie_off");
      rd(2'd1, 8'h04, "gie_off_pend");
      wr(2'd3, 8'h80);
      tick();
      chk_out(1'b1, 2'd2, "gie_on");

      // Reset overrides a simultaneous write; line held high through reset
      rst        = 1'b1;
      irq_in     = 4'b0100;
      bus.io_we  = 1'b1;
      bus.io_a   = 2'd0;
      bus.io_din = 8'h0F;
      tick();
      rst        = 1'b0;
      bus.io_we  = 1'b0;
      bus.io_din = 8'h00;
      chk_out(1'b0, 2'd0, "rst2_outputs");
      rd(2'd1, 8'h00, "rst2_pending");
      rd(2'd0, 8'h00, "rst2_override_wr");
      rd(2'd3, 8'h00, "rst2_ctrl");
      wr(2'd0, 8'h0F);
      wr(2'd3, 8'h80);
      tick();
      rd(2'd1, 8'h00, "no_edge_thru_rst");
      chk_out(1'b0, 2'd0, "no_irq_thru_rst");
      irq_in = 4'b0000;
      tick();
      irq_in = 4'b0100;
      tick();
      irq_in = 4'b0000;
      rd(2'd1, 8'h04, "edge_after_low");
      tick();
      chk_out(1'b1, 2'd2, "irq_after_low");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/avr_irq_ctrl.md
AVR_IRQ_CTRL -- requirements
Module: avr_irq_ctrl

Interface
REQ-001 SHALL have parameter RESET_ENABLE, default 4'b0000, reset value of the ENABLE register.
REQ-002 SHALL have parameter RESET_MODE, default 4'b0000, reset value of the MODE register (1 = edge, 0 = level).
REQ-003 clk  input  1  system clock; single clock domain; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 irq_in  input  4  interrupt request lines from peripherals; index 0 is highest priority.
REQ-006 io_re  input  1  I/O read strobe, already qualified by this block's address select.
REQ-007 io_we  input  1  I/O write strobe, already qualified by this block's address select.
REQ-008 io_a  input  2  register address.
REQ-009 io_din  input  8  write data from the core.
REQ-010 io_dout  output  8  read data to the core I/O bus.
REQ-011 ieack_stb  input  1  one-cycle pulse from the core when it takes an interrupt.
REQ-012 ieack  input  2  vector being acknowledged; valid with ieack_stb.
REQ-013 iflag  output  1  interrupt request to the core (registered).
REQ-014 ivect  output  2  vector of the highest-priority active source (registered).

Function
REQ-015 Registers: 0 ENABLE[3:0] (R/W); 1 PENDING[3:0] (R; W1C); 2 MODE[3:0] (R/W); 3 CTRL (bit7 GIE R/W; bits1:0 ivect R/O; bit6 iflag R/O).
REQ-016 Unused read bits SHALL read 0. io_dout SHALL be combinational from io_a when io_re=1, and 8'h00 when io_re=0, so the block is safe on a wired-OR bus.
REQ-017 irq_q[3:0] SHALL register irq_in every cycle for edge detection.
REQ-018 Edge source i: pending[i] SHALL set on the clock after the cycle where irq_in[i]=1 and irq_q[i]=0. pending[i] stays set until cleared by a W1C write or an acknowledge.
REQ-019 Level source i: pending[i] SHALL load irq_in[i] every clock. W1C writes and acknowledges SHALL have no lasting effect on level sources.
REQ-020 active = pending & ENABLE & {4{GIE}}. ivect SHALL be the lowest set index of active, or 0 if active is empty.
REQ-021 iflag and ivect SHALL register iflag=|active and ivect from the previous cycle's pending. Latency from the irq_in rising edge to iflag=1 is exactly 2 clocks.
REQ-022 Acknowledge: ieack_stb=1 SHALL clear pending[ieack] if that source is in edge mode. Any other source is unaffected.
REQ-023 W1C: a write to address 1 SHALL clear pending[i] for each io_din[i]=1 (edge sources only).
REQ-024 Simultaneous events: a new edge in the same cycle as a W1C clear or an acknowledge of the same bit SHALL leave pending set (set wins).
REQ-025 Writing MODE SHALL clear pending for every source whose mode bit changes. Unchanged sources keep their pending state.
REQ-026 Clearing ENABLE[i] or GIE SHALL drop iflag 1 clock later without altering pending. Re-enabling SHALL reassert iflag 1 clock later if still pending.
REQ-027 Writes and reads to addresses outside 0-3 cannot occur (2-bit address). A write to address 3 SHALL update only GIE.

Reset
REQ-028 On rst=1 at a clock edge: ENABLE=RESET_ENABLE, MODE=RESET_MODE, GIE=0, pending=0, irq_q=0, iflag=0, ivect=0.
REQ-029 rst SHALL override all simultaneous writes, edges and acknowledges in the same cycle.
REQ-030 Reset mid-pending SHALL discard all pending edges. A line held high through reset in edge mode SHALL NOT produce an edge (irq_q is reset to 0, but the edge is only detected after reset is released and only if the line is seen low first).

Verification
REQ-031 ENABLE=4'hF, MODE=4'hF, GIE=1; pulse irq_in[2] one cycle -> iflag=1, ivect=2 exactly 2 clocks later; PENDING reads 4'h4.
REQ-032 Edge-pending on sources 1 and 3 -> ivect=1. Ack ieack=1 -> next cycle PENDING=4'h8. One cycle later iflag=1, ivect=3.
REQ-033 Level source 0 held high, GIE=1, ENABLE[0]=1 -> iflag stays 1 through ack and W1C of bit 0. Drop irq_in[0] -> iflag=0 2 clocks later.
REQ-034 Edge on source 1 in the same cycle as a W1C of 8'h02 -> PENDING[1]=1 afterwards.
REQ-035 Pending source 2 with ENABLE=4'h0 -> iflag=0. Write ENABLE=4'h4 -> iflag=1 and ivect=2 1 clock later. Then assert rst -> all outputs 0 and PENDING=0.
REQ-036 io_re=0 -> io_dout=8'h00. Read address 3 with GIE=1, iflag=1, ivect=2 -> 8'hC2.
